mem_stage: RTL and testbench

Memory stage of the 16-bit five-stage pipeline. It sits between the EX/MEM and MEM/WB pipeline registers and consumes their held control and data. It resolves the next PC, performs loads and stores through a multi-cycle data-memory handshake, and stalls all upstream stages while an access is outstanding. It also tracks halt and memory-error status for the rest of the core.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline memory stage (next-PC, multi-cycle load/store, stall)
// Optional: MEM_ALIGN_CHECK_EN enables odd-address access rejection.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] readData2_in,
  input  logic        MemRead_in,
  input  logic        MemWrt_in,
  input  logic        halt_in,
  input  logic        branchtake_in,
  input  logic        PC_or_add_in,
  input  logic        ALUJmp_in,
  input  logic [15:0] SgnExt_in,
  input  logic [15:0] pc2_in,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        dm_rd,
  output logic        dm_wr,
  input  logic [15:0] dm_rdata,
  input  logic        dm_done,
  output logic [15:0] newPC,
  output logic [15:0] mem_data_out,
  output logic        stall,
  output logic        wb_valid_out,
  output logic        halt_out,
  output logic        err_out
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [15:0] data_q;
  logic        halt_q;
  logic        err_q;
  logic        rd_op_q;
  logic        access;
  logic        misalign;
  logic        timeout;

  assign access  = valid_in & (MemRead_in | MemWrt_in) & ~halt_q;
  assign cnt_inc = cnt + 8'd1;
  assign timeout = (cnt_inc == MAX_W);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = alu_in[0];
`else
  assign misalign = 1'b0;
`endif

  assign dm_addr      = alu_in;
  assign dm_wdata     = readData2_in;
  assign mem_data_out = data_q;
  assign halt_out     = halt_q;
  assign err_out      = err_q;
  assign wb_valid_out = valid_in & ~stall;

  always_comb begin
    if (ALUJmp_in)
      newPC = alu_in;
    else if (branchtake_in || PC_or_add_in)
      newPC = pc2_in + SgnExt_in;
    else
      newPC = pc2_in;
  end

  always_comb begin
    state_nxt = state;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misalign) begin
          // Write takes precedence when both read and write are flagged.
          dm_wr     = MemWrt_in;
          dm_rd     = MemRead_in & ~MemWrt_in;
          stall     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dm_done || timeout)
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      data_q  <= 16'h0000;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_op_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (access && !misalign) begin
            cnt     <= 8'd0;
            rd_op_q <= MemRead_in & ~MemWrt_in;
          end else if (access && misalign) begin
            err_q  <= 1'b1;
            data_q <= 16'hFFFF;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          // A completion in the final allowed cycle beats the timeout.
          if (dm_done) begin
            if (rd_op_q)
              data_q <= dm_rdata;
          end else if (timeout) begin
            err_q  <= 1'b1;
            data_q <= 16'hFFFF;
          end
        end
        default: begin
        end
      endcase
      if ((state == IDLE || state == DONE) && valid_in && halt_in)
        halt_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed + randomized checks of mem_stage against a
// transaction-level reference model.
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_in;
  logic [15:0] readData2_in;
  logic        MemRead_in;
  logic        MemWrt_in;
  logic        halt_in;
  logic        branchtake_in;
  logic        PC_or_add_in;
  logic        ALUJmp_in;
  logic [15:0] SgnExt_in;
  logic [15:0] pc2_in;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic [15:0] newPC;
  logic [15:0] mem_data_out;
  logic        stall;
  logic        wb_valid_out;
  logic        halt_out;
  logic        err_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_data;
  logic        m_err;
  logic        m_halt;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_in(alu_in),
    .readData2_in(readData2_in), .MemRead_in(MemRead_in), .MemWrt_in(MemWrt_in),
    .halt_in(halt_in), .branchtake_in(branchtake_in), .PC_or_add_in(PC_or_add_in),
    .ALUJmp_in(ALUJmp_in), .SgnExt_in(SgnExt_in), .pc2_in(pc2_in),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .newPC(newPC),
    .mem_data_out(mem_data_out), .stall(stall), .wb_valid_out(wb_valid_out),
    .halt_out(halt_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k: cycles from request to dm_done (0 = never); early: extra dm_done
  // pulse in the request cycle, which must be ignored.
  task automatic run_instr(input logic v, input logic rd, input logic wr, input logic hlt,
                           input logic bt, input logic pcadd, input logic aj,
                           input logic [15:0] alu, input logic [15:0] wd,
                           input logic [15:0] sext, input logic [15:0] pc2,
                           input logic [15:0] rdata, input int k, input bit early);
    logic [15:0] exp_pc;
    logic        acc, mis, issue, tmo, load;
    int          exp_stall, c, req_cyc, nst, nrd, nwr;
    bit          left;
    logic [15:0] got_wd, got_addr, got_data;

    valid_in = v; MemRead_in = rd; MemWrt_in = wr; halt_in = hlt;
    branchtake_in = bt; PC_or_add_in = pcadd; ALUJmp_in = aj;
    alu_in = alu; readData2_in = wd; SgnExt_in = sext; pc2_in = pc2;
    dm_rdata = rdata; dm_done = 1'b0;

    if (aj) exp_pc = alu;
    else if (bt || pcadd) exp_pc = 16'((32'(pc2) + 32'(sext)) % 65536);
    else exp_pc = pc2;

    acc = v & (rd | wr) & ~m_halt;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc & alu[0];
`else
    mis = 1'b0;
`endif
    issue     = acc & ~mis;
    tmo       = issue && (k == 0 || k > MW);
    load      = rd & ~wr;
    exp_stall = !issue ? 0 : (tmo ? MW + 1 : k + 1);

    c = 0; req_cyc = -1; nst = 0; nrd = 0; nwr = 0; left = 0;
    got_wd = '0; got_addr = '0; got_data = '0;
    while (!left && c < 300) begin
      @(negedge clk);
      if (c == 0) check("newPC", 32'(newPC), 32'(exp_pc));
      if (dm_rd || dm_wr) begin
        req_cyc  = c;
        got_wd   = dm_wdata;
        got_addr = dm_addr;
      end
      if (dm_rd) nrd++;
      if (dm_wr) nwr++;
      if (stall) nst++;
      if (!v) begin
        check("bubble_wb", 32'(wb_valid_out), 32'd0);
        check("bubble_stall", 32'(stall), 32'd0);
        left = 1;
      end else if (wb_valid_out) begin
        left     = 1;
        got_data = mem_data_out;
      end
      dm_done = (req_cyc >= 0) &&
                ((early && c == req_cyc) || (k > 0 && c == req_cyc + k));
      c++;
      @(posedge clk); #1;
      dm_done = 1'b0;
    end

    if (tmo || mis) begin
      m_err  = 1'b1;
      m_data = 16'hFFFF;
    end else if (issue && load) begin
      m_data = rdata;
    end
    if (v && hlt) m_halt = 1'b1;

    if (v) begin
      check("left_stage", 32'(left), 32'd1);
      check("stall_cycles", 32'(nst), 32'(exp_stall));
      check("rd_pulses", 32'(nrd), 32'(issue && load));
      check("wr_pulses", 32'(nwr), 32'(issue && wr));
      if (issue) begin
        check("dm_wdata", 32'(got_wd), 32'(wd));
        check("dm_addr", 32'(got_addr), 32'(alu));
      end
      if ((issue && load) || tmo || mis)
        check("mem_data", 32'(got_data), 32'(m_data));
    end
    check("err_out", 32'(err_out), 32'(m_err));
    check("halt_out", 32'(halt_out), 32'(m_halt));
  endtask

  initial begin
    rst = 1'b1; valid_in = 0; alu_in = 0; readData2_in = 0; MemRead_in = 0;
    MemWrt_in = 0; halt_in = 0; branchtake_in = 0; PC_or_add_in = 0;
    ALUJmp_in = 0; SgnExt_in = 0; pc2_in = 0; dm_rdata = 0; dm_done = 0;
    m_data = 16'h0000; m_err = 1'b0; m_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dm_rd", 32'(dm_rd), 32'd0);
    check("rst_dm_wr", 32'(dm_wr), 32'd0);
    check("rst_wb", 32'(wb_valid_out), 32'd0);
    check("rst_halt", 32'(halt_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_data", 32'(mem_data_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load, dm_done at k=3.
    run_instr(1, 1, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0100, 16'hBEEF, 3, 0);
    // Read+write both set: write wins.
    run_instr(1, 1, 1, 0, 0, 0, 0, 16'h0044, 16'h1234, 16'h0000, 16'h0102, 16'h5555, 2, 0);
    // Branch and register jump, no memory access.
    run_instr(1, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'hFFF8, 16'h0010, 16'h0000, 1, 0);
    run_instr(1, 0, 0, 0, 0, 0, 1, 16'h0200, 16'h0000, 16'h0004, 16'h0010, 16'h0000, 1, 0);
    run_instr(1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0004, 16'hFFFE, 16'h0000, 1, 0);
    // Early dm_done in the request cycle is ignored.
    run_instr(1, 1, 0, 0, 0, 0, 0, 16'h0046, 16'h0000, 16'h0000, 16'h0104, 16'hCAFE, 2, 1);
    // Timeout.
    run_instr(1, 1, 0, 0, 0, 0, 0, 16'h0048, 16'h0000, 16'h0000, 16'h0106, 16'h1111, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0, 0, 16'h004A, 16'h0000, 16'h0000, 16'h0108, 16'h2222, 1, 0);

    // Reset while waiting, then a late dm_done.
    valid_in = 1; MemRead_in = 1; MemWrt_in = 0; alu_in = 16'h0080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 0; MemRead_in = 0;
    dm_done = 1'b1; dm_rdata = 16'hABCD;
    m_data = 16'h0000; m_err = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    check("wrst_stall", 32'(stall), 32'd0);
    check("wrst_err", 32'(err_out), 32'd0);
    @(posedge clk); #1;
    dm_done = 1'b0;
    @(negedge clk);
    check("wrst_data", 32'(mem_data_out), 32'd0);
    check("wrst_stall2", 32'(stall), 32'd0);
    check("wrst_rd", 32'(dm_rd), 32'd0);
    @(posedge clk); #1;

    // Randomized mix of loads, stores, jumps and bubbles.
    for (int i = 0; i < 40; i++) begin
      logic        v, rd, wr, bt, pa, aj;
      logic [15:0] alu, wd, sx, pc2, rdv;
      int          k;
      v   = ($urandom_range(0, 7) != 0);
      rd  = $urandom_range(0, 1) == 1;
      wr  = $urandom_range(0, 2) == 0;
      bt  = $urandom_range(0, 3) == 0;
      pa  = $urandom_range(0, 5) == 0;
      aj  = $urandom_range(0, 5) == 0;
      alu = 16'($urandom);
      wd  = 16'($urandom);
      sx  = 16'($urandom) & 16'hFFFE;
      pc2 = 16'($urandom) & 16'hFFFE;
      rdv = 16'($urandom);
      k   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      run_instr(v, rd, wr, 0, bt, pa, aj, alu, wd, sx, pc2, rdv, k, $urandom_range(0, 4) == 0);
    end

`ifdef MEM_ALIGN_CHECK_EN
    run_instr(1, 1, 0, 0, 0, 0, 0, 16'h0041, 16'h0000, 16'h0000, 16'h0010, 16'h7777, 2, 0);
`endif

    // HALT, then a load that must not issue.
    run_instr(1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 1, 0);
    run_instr(1, 1, 0, 0, 0, 0, 0, 16'h0050, 16'h0000, 16'h0000, 16'h0022, 16'h3333, 2, 0);
    run_instr(1, 0, 1, 0, 0, 0, 0, 16'h0052, 16'h4444, 16'h0000, 16'h0024, 16'h0000, 2, 0);
    valid_in = 0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", 32'(halt_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
